// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the MEM-stage data-memory controller.
package cpu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } dmem_state_e;

   localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: store lane replication / byte enables, load extraction and alignment check.
// Sub-word accesses exist only when DMEM_BYTE_ACCESS_EN is defined; otherwise all accesses are words.
module dmem_lane
   import cpu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_unsigned,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic        o_bad,
   output logic [3:0]  o_we,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);

`ifdef DMEM_BYTE_ACCESS_EN
   logic [31:0] w_shift;

   always_comb begin
      o_bad   = 1'b0;
      o_we    = 4'b0000;
      o_wdata = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_we    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            o_bad   = i_off[0];
            o_we    = i_off[1] ? 4'b1100 : 4'b0011;
            o_wdata = {2{i_wdata[15:0]}};
         end
         SZ_WORD: begin
            o_bad = (i_off != 2'b00);
            o_we  = 4'b1111;
         end
         default: o_bad = 1'b1;
      endcase
   end

   // Bring the addressed lane down to bit 0 before extending.
   assign w_shift = i_rdata >> {i_ld_off, 3'b000};

   always_comb begin
      case (i_ld_size)
         SZ_BYTE: o_ldata = i_ld_unsigned ? {24'h000000, w_shift[7:0]}
                                          : {{24{w_shift[7]}}, w_shift[7:0]};
         SZ_HALF: o_ldata = i_ld_unsigned ? {16'h0000, w_shift[15:0]}
                                          : {{16{w_shift[15]}}, w_shift[15:0]};
         default: o_ldata = i_rdata;
      endcase
   end
`else
   logic w_unused;

   assign o_bad    = (i_off != 2'b00);
   assign o_we     = 4'b1111;
   assign o_wdata  = i_wdata;
   assign o_ldata  = i_rdata;
   assign w_unused = ^{i_size, i_ld_size, i_ld_unsigned, i_ld_off};
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-RAM controller; load FSM, read-latency counter and held read data.
// Byte/half accesses are enabled by defining DMEM_BYTE_ACCESS_EN (word-only when undefined).
module dmem_ctrl
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              Mem_read,
   input  logic              Mem_write,
   input  logic [1:0]        Mem_size,
   input  logic              Mem_unsigned,
   input  logic [31:0]       ALU_Result,
   input  logic [31:0]       Read_data_2,
   output logic [31:0]       Mem_data,
   output logic              Mem_stall,
   output logic              Addr_err,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [2:0] LP_CNT_INIT = 3'(RD_LAT - 1);

   dmem_state_e r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_rdata_q;
   logic [1:0]  r_ld_size;
   logic        r_ld_unsigned;
   logic [1:0]  r_ld_off;

   logic        w_bad;
   logic        w_idle;
   logic        w_rd_acc;
   logic        w_wr_acc;
   logic [3:0]  w_we;
   logic        w_unused;

   dmem_lane u_lane (
      .i_size        (Mem_size),
      .i_off         (ALU_Result[1:0]),
      .i_wdata       (Read_data_2),
      .i_ld_size     (r_ld_size),
      .i_ld_unsigned (r_ld_unsigned),
      .i_ld_off      (r_ld_off),
      .i_rdata       (r_rdata_q),
      .o_bad         (w_bad),
      .o_we          (w_we),
      .o_wdata       (ram_wdata),
      .o_ldata       (Mem_data)
   );

   // Gating with rst_n lets the stall and RAM enable drop the moment reset asserts.
   assign w_idle    = rst_n && (r_state == IDLE);
   assign Addr_err  = w_idle && (Mem_read || Mem_write) && (w_bad || (Mem_read && Mem_write));
   assign w_rd_acc  = w_idle && Mem_read && !Mem_write && !w_bad;
   assign w_wr_acc  = w_idle && Mem_write && !Mem_read && !w_bad;
   assign Mem_stall = w_rd_acc || (r_state == WAIT);
   assign ram_en    = w_rd_acc || w_wr_acc;
   assign ram_we    = w_wr_acc ? w_we : 4'b0000;
   assign ram_addr  = ALU_Result[ADDR_W+1:2];
   assign w_unused  = ^ALU_Result[31:ADDR_W+2];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= 3'd0;
         r_rdata_q     <= 32'h0;
         r_ld_size     <= 2'b00;
         r_ld_unsigned <= 1'b0;
         r_ld_off      <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rd_acc) begin
                  r_state       <= WAIT;
                  r_cnt         <= LP_CNT_INIT;
                  r_ld_size     <= Mem_size;
                  r_ld_unsigned <= Mem_unsigned;
                  r_ld_off      <= ALU_Result[1:0];
               end
            end
            WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_rdata_q <= ram_rdata;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench with a load-data scoreboard; one DUT at RD_LAT=1, one at RD_LAT=3.
module tb_dmem_ctrl;
   import cpu_pkg::*;

   localparam int AW = 14;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          rst_n_a, rst_n_b;
   logic          mem_read, mem_write, mem_unsigned;
   logic [1:0]    mem_size;
   logic [31:0]   alu_result, read_data_2;
   logic [31:0]   mem_data_a, mem_data_b;
   logic          stall_a, stall_b, err_a, err_b, en_a, en_b;
   logic [3:0]    we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [31:0]   wdata_a, wdata_b, rdata_a, rdata_b;

   logic [31:0]   ram_word;
   logic [31:0]   pipe_a;
   logic [31:0]   pipe_b [0:2];

   // RAM model: returns ram_word exactly RD_LAT cycles after a read enable, garbage otherwise.
   always @(posedge clock) begin
      pipe_a    <= (en_a && we_a == 4'b0000) ? ram_word : 32'hDEAD_BEEF;
      pipe_b[0] <= (en_b && we_b == 4'b0000) ? ram_word : 32'hDEAD_BEEF;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign rdata_a = pipe_a;
   assign rdata_b = pipe_b[2];

   dmem_ctrl #(.ADDR_W(AW), .RD_LAT(1)) u_dut_a (
      .clock(clock), .rst_n(rst_n_a), .Mem_read(mem_read), .Mem_write(mem_write),
      .Mem_size(mem_size), .Mem_unsigned(mem_unsigned), .ALU_Result(alu_result),
      .Read_data_2(read_data_2), .Mem_data(mem_data_a), .Mem_stall(stall_a),
      .Addr_err(err_a), .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a),
      .ram_wdata(wdata_a), .ram_rdata(rdata_a)
   );

   dmem_ctrl #(.ADDR_W(AW), .RD_LAT(3)) u_dut_b (
      .clock(clock), .rst_n(rst_n_b), .Mem_read(mem_read), .Mem_write(mem_write),
      .Mem_size(mem_size), .Mem_unsigned(mem_unsigned), .ALU_Result(alu_result),
      .Read_data_2(read_data_2), .Mem_data(mem_data_b), .Mem_stall(stall_b),
      .Addr_err(err_b), .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b),
      .ram_wdata(wdata_b), .ram_rdata(rdata_b)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] sb_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] sel_data(input int s);
      return (s == 0) ? mem_data_a : mem_data_b;
   endfunction
   function automatic logic [31:0] sel_stall(input int s);
      return {31'b0, (s == 0) ? stall_a : stall_b};
   endfunction
   function automatic logic [31:0] sel_en(input int s);
      return {31'b0, (s == 0) ? en_a : en_b};
   endfunction
   function automatic logic [31:0] sel_addr(input int s);
      return {18'b0, (s == 0) ? addr_a : addr_b};
   endfunction

   task automatic do_load(input int s, input int lat, input string tag, input logic [31:0] addr,
                          input logic [1:0] sz, input logic uns, input logic [31:0] word,
                          input logic [31:0] exp);
      int          cyc;
      logic [31:0] en_late;
      logic [31:0] exp_pop;
      ram_word = word;
      @(negedge clock);
      alu_result   = addr;
      mem_size     = sz;
      mem_unsigned = uns;
      mem_write    = 1'b0;
      mem_read     = 1'b1;
      sb_q.push_back(exp);
      #1;
      check({tag, " en_issue"}, sel_en(s), 32'd1);
      check({tag, " stall_issue"}, sel_stall(s), 32'd1);
      check({tag, " addr"}, sel_addr(s), {18'b0, addr[AW+1:2]});
      cyc     = 1;
      en_late = 32'd0;
      while (sel_stall(s) === 32'd1 && cyc < 20) begin
         @(negedge clock);
         #1;
         cyc++;
         en_late = en_late | sel_en(s);
      end
      check({tag, " cycles"}, cyc, lat + 2);
      check({tag, " en_after_issue"}, en_late, 32'd0);
      exp_pop = sb_q.pop_front();
      check({tag, " data"}, sel_data(s), exp_pop);
      $display("load %s: addr=%h cycles=%0d data=%h", tag, addr, cyc, sel_data(s));
      @(negedge clock);
      mem_read = 1'b0;
      #1;
      check({tag, " data_hold"}, sel_data(s), exp_pop);
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] data, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata);
      @(negedge clock);
      alu_result  = addr;
      mem_size    = sz;
      read_data_2 = data;
      mem_read    = 1'b0;
      mem_write   = 1'b1;
      #1;
      check({tag, " en"}, {31'b0, en_a}, 32'd1);
      check({tag, " we"}, {28'b0, we_a}, {28'b0, exp_we});
      check({tag, " wdata"}, wdata_a, exp_wdata);
      check({tag, " stall"}, {31'b0, stall_a}, 32'd0);
      $display("store %s: addr=%h we=%b wdata=%h", tag, addr, we_a, wdata_a);
      @(negedge clock);
      mem_write = 1'b0;
      #1;
      check({tag, " stall_after"}, {31'b0, stall_a}, 32'd0);
   endtask

   task automatic do_err(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                         input logic rd, input logic wr);
      @(negedge clock);
      alu_result = addr;
      mem_size   = sz;
      mem_read   = rd;
      mem_write  = wr;
      #1;
      check({tag, " err"}, {31'b0, err_a}, 32'd1);
      check({tag, " en"}, {31'b0, en_a}, 32'd0);
      check({tag, " stall"}, {31'b0, stall_a}, 32'd0);
      $display("error %s: addr=%h err=%b en=%b stall=%b", tag, addr, err_a, en_a, stall_a);
      @(negedge clock);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      check({tag, " idle_after"}, {31'b0, stall_a}, 32'd0);
   endtask

   initial begin
      rst_n_a      = 1'b0;
      rst_n_b      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_size     = SZ_WORD;
      mem_unsigned = 1'b0;
      alu_result   = 32'h0;
      read_data_2  = 32'h0;
      ram_word     = 32'h0;
      repeat (2) @(negedge clock);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      #1;
      check("reset data", mem_data_a, 32'h0);
      check("reset stall", {31'b0, stall_a}, 32'd0);
      check("reset err", {31'b0, err_a}, 32'd0);
      check("reset en", {31'b0, en_a}, 32'd0);
      check("reset we", {28'b0, we_a}, 32'd0);
      $display("reset: data=%h stall=%b err=%b en=%b we=%b", mem_data_a, stall_a, err_a, en_a, we_a);

      do_load(0, 1, "word_0x100", 32'h100, SZ_WORD, 1'b0, 32'h8000_1234, 32'h8000_1234);

`ifdef DMEM_BYTE_ACCESS_EN
      do_load(0, 1, "byte_s_0x103", 32'h103, SZ_BYTE, 1'b0, 32'h80FF_FFFF, 32'hFFFF_FF80);
      do_load(0, 1, "byte_u_0x103", 32'h103, SZ_BYTE, 1'b1, 32'h80FF_FFFF, 32'h0000_0080);
      do_load(0, 1, "half_s_0x102", 32'h102, SZ_HALF, 1'b0, 32'h80FF_1234, 32'hFFFF_80FF);
      do_store("half_0x202", 32'h202, SZ_HALF, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
      do_store("byte_0x300", 32'h300, SZ_BYTE, 32'h1234_5678, 4'b0001, 32'h7878_7878);
      do_err("size11", 32'h100, 2'b11, 1'b1, 1'b0);
      do_err("half_misalign", 32'h105, SZ_HALF, 1'b1, 1'b0);
`else
      do_err("byte_0x103_word", 32'h103, SZ_BYTE, 1'b1, 1'b0);
      do_load(0, 1, "bytesz_0x104", 32'h104, SZ_BYTE, 1'b0, 32'h80FF_FFFF, 32'h80FF_FFFF);
      do_store("half_0x204_word", 32'h204, SZ_HALF, 32'h0000_ABCD, 4'b1111, 32'h0000_ABCD);
      do_store("byte_0x300_word", 32'h300, SZ_BYTE, 32'h1234_5678, 4'b1111, 32'h1234_5678);
`endif
      do_err("misalign_0x101", 32'h101, SZ_WORD, 1'b1, 1'b0);
      do_err("rd_and_wr", 32'h100, SZ_WORD, 1'b1, 1'b1);
      do_store("word_0x308", 32'h308, SZ_WORD, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);

      // Second DUT (RD_LAT=3): drain, one clean load, then reset in the middle of a read.
      repeat (8) @(negedge clock);
      do_load(1, 3, "lat3_word", 32'h110, SZ_WORD, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA);
      @(negedge clock);
      alu_result = 32'h120;
      mem_size   = SZ_WORD;
      ram_word   = 32'h1111_2222;
      mem_read   = 1'b1;
      #1;
      check("lat3_rst stall_issue", {31'b0, stall_b}, 32'd1);
      @(negedge clock);
      #1;
      check("lat3_rst stall_wait", {31'b0, stall_b}, 32'd1);
      rst_n_b = 1'b0;
      #1;
      check("lat3_rst stall_drop", {31'b0, stall_b}, 32'd0);
      check("lat3_rst data", mem_data_b, 32'h0);
      check("lat3_rst en", {31'b0, en_b}, 32'd0);
      $display("reset mid-read: stall=%b data=%h en=%b", stall_b, mem_data_b, en_b);
      @(negedge clock);
      mem_read = 1'b0;
      rst_n_b  = 1'b1;
      #1;
      @(negedge clock);
      #1;
      check("lat3_rst idle_after", {31'b0, stall_b}, 32'd0);
      check("lat3_rst data_after", mem_data_b, 32'h0);
      do_load(1, 3, "lat3_after_rst", 32'h124, SZ_WORD, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
